instr_fetch_unit: RTL

Fetch stage of the 5-stage pipeline: owns the PC, issues single-outstanding requests to instruction memory, and presents fetched PC/instruction pairs to the IF/ID pipeline register. It honours the hazard unit's stall, applies EX-stage redirects (branch/jump) with kill of in-flight fetches, and emits zero bubbles whenever no valid instruction is available.

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/next_pc_gen.sv | 29 ++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// +--------------------------------------------------------------------------+
// | pipeline_pkg : fetch-stage types, constants and alignment helper        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Clears the byte-offset bits so any address lands on an instruction boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(INSTR_BYTES - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_gen.sv
// +--------------------------------------------------------------------------+
// | next_pc_gen : selects redirect target / pc+4 / hold for the fetch PC     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module next_pc_gen
  import pipeline_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        advance_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_i;
    if (redirect_i) begin
      next_pc_o = word_align(redirect_pc_i);
    end else if (advance_i) begin
      // Wraps past 32'hFFFF_FFFC to zero by plain modular addition.
      next_pc_o = pc_i + INSTR_BYTES;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | instr_fetch_unit : PC owner and single-outstanding imem fetch stage;     |
// | optional FETCH_MISALIGN_TRAP_EN adds fetch_misalign. Revision 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fetch_busy
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic         advance;

  next_pc_gen u_next_pc_gen (
    .pc_i          (pc_q),
    .advance_i     (advance),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .next_pc_o     (pc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= BUBBLE_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    advance     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_out      = 32'h0;
    instr_out   = BUBBLE_INSTR;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !redirect) begin
          instr_valid = 1'b1;
          pc_out      = pc_q;
          instr_out   = imem_rdata;
          if (stall) begin
            state_d     = HOLD;
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata;
          end else begin
            advance = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!redirect) begin
          instr_valid = 1'b1;
          pc_out      = buf_pc_q;
          instr_out   = buf_instr_q;
          if (!stall) begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end
      end
      KILL: begin
        if (imem_ready) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Redirect overrides everything; KILL is needed only while memory still owes a response.
    if (redirect) begin
      buf_pc_d    = 32'h0;
      buf_instr_d = BUBBLE_INSTR;
      if ((state_q == FETCH || state_q == KILL) && !imem_ready) begin
        state_d = KILL;
      end else begin
        state_d = FETCH;
      end
    end
  end

  assign imem_addr  = pc_q;
  assign fetch_busy = (state_q == FETCH) || (state_q == KILL);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect && (redirect_pc[1:0] != 2'b00);
    end
  end

  assign fetch_misalign = misalign_q;
`endif

endmodule

`default_nettype wire
